store_buffer: RTL and testbench

- Holds stores between the memory stage and commit.
- Entries are allocated in program order. The ROB marks an entry committed when the store retires; the ROB discards uncommitted entries on a branch-taken flush.
- Committed entries drain oldest-first to the data memory write port through a req/ack handshake.
- Provides same-cycle store-to-load forwarding for the memory stage.

---
 rtl/tartaruga_pkg.sv | 40 ++++
 rtl/sb_forward_unit.sv | 42 ++++
 rtl/store_buffer.sv | 148 ++++++++++++++
 tb/tb_store_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core: bus/index typedefs and store buffer entry layout.
package tartaruga_pkg;

  localparam int unsigned STORE_BUFFER_SIZE = 4;

  typedef logic [$clog2(STORE_BUFFER_SIZE)-1:0] store_buffer_idx_t;
  typedef logic [31:0] bus32_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    PENDING   = 2'd1,
    COMMITTED = 2'd2,
    DRAINING  = 2'd3
  } sb_state_t;

  typedef struct packed {
    sb_state_t   state;
    logic [29:0] waddr;
    logic [3:0]  be;
    bus32_t      data;
  } sb_entry_t;

  // Byte-lane mask of an access; an unknown size code is treated as a word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      BYTE:    m = 4'b0001;
      HALF:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/sb_forward_unit.sv
// Combinational store-to-load forwarding: youngest overlapping store entry decides hit/stall.
module sb_forward_unit
  import tartaruga_pkg::*;
#(
  parameter int unsigned SB_SIZE = STORE_BUFFER_SIZE,
  parameter int unsigned IDX_W   = $clog2(SB_SIZE)
) (
  input  sb_entry_t        entries_i [SB_SIZE],
  input  logic [IDX_W-1:0] head_i,
  input  bus32_t           ld_addr_i,
  input  logic [1:0]       ld_size_i,
  output logic             fwd_hit_o,
  output bus32_t           fwd_data_o,
  output logic             fwd_stall_o
);

  logic [3:0]       ld_mask;
  logic             match;
  sb_entry_t        sel;
  logic [IDX_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    ld_mask = byte_mask(ld_size_i, ld_addr_i[1:0]);
    match   = 1'b0;
    sel     = '0;
    idx     = head_i;
    for (int unsigned k = 0; k < SB_SIZE; k++) begin
      idx = head_i + IDX_W'(k);
      if (entries_i[idx].state != FREE &&
          entries_i[idx].waddr == ld_addr_i[31:2] &&
          |(entries_i[idx].be & ld_mask)) begin
        match = 1'b1;
        sel   = entries_i[idx];
      end
    end
    fwd_hit_o   = match && ((sel.be & ld_mask) == ld_mask);
    fwd_stall_o = match && !fwd_hit_o;
    fwd_data_o  = fwd_hit_o ? sel.data : '0;
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between memory stage and commit: in-order allocation, ROB commit/discard,
// oldest-first drain to the data memory write port, and store-to-load forwarding.
module store_buffer
  import tartaruga_pkg::*;
#(
  parameter int unsigned SB_SIZE = STORE_BUFFER_SIZE,
  parameter int unsigned IDX_W   = $clog2(SB_SIZE)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alloc_valid_i,
  input  bus32_t             alloc_addr_i,
  input  bus32_t             alloc_data_i,
  input  logic [1:0]         alloc_size_i,
  output logic               alloc_ready_o,
  output logic [IDX_W-1:0]   alloc_idx_o,
  input  logic               commit_valid_i,
  input  logic               commit_store_to_mem_i,
  input  logic [IDX_W-1:0]   commit_idx_i,
  input  logic [SB_SIZE-1:0] discard_i,
  input  bus32_t             ld_addr_i,
  input  logic [1:0]         ld_size_i,
  output logic               fwd_hit_o,
  output bus32_t             fwd_data_o,
  output logic               fwd_stall_o,
  output logic               mem_req_o,
  output bus32_t             mem_addr_o,
  output bus32_t             mem_data_o,
  output logic [3:0]         mem_be_o,
  input  logic               mem_ack_i,
  output logic               empty_o
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic {D_IDLE, D_REQ} drain_state_t;

  sb_entry_t        entries_q [SB_SIZE];
  sb_entry_t        entries_d [SB_SIZE];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, n_disc;
  drain_state_t     dstate_q, dstate_d;
  bus32_t           mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             do_alloc, do_free, any_disc;

  assign alloc_ready_o = (count_q != CNT_W'(SB_SIZE));
  assign alloc_idx_o   = tail_q;
  assign empty_o       = (count_q == '0);
  assign mem_req_o     = (dstate_q == D_REQ);
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign mem_be_o      = mem_be_q;

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    dstate_d   = dstate_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_be_d   = mem_be_q;
    do_alloc   = alloc_valid_i && alloc_ready_o;
    do_free    = 1'b0;
    any_disc   = 1'b0;
    n_disc     = '0;

    case (dstate_q)
      D_IDLE: begin
        if (entries_q[head_q].state == COMMITTED) begin
          entries_d[head_q].state = DRAINING;
          dstate_d   = D_REQ;
          mem_addr_d = {entries_q[head_q].waddr, 2'b00};
          mem_data_d = entries_q[head_q].data;
          mem_be_d   = entries_q[head_q].be;
        end
      end
      default: begin
        if (mem_ack_i) begin
          entries_d[head_q].state = FREE;
          head_d     = head_q + 1'b1;
          dstate_d   = D_IDLE;
          do_free    = 1'b1;
          mem_addr_d = '0;
          mem_data_d = '0;
          mem_be_d   = '0;
        end
      end
    endcase

    if (commit_valid_i && commit_store_to_mem_i && entries_q[commit_idx_i].state == PENDING)
      entries_d[commit_idx_i].state = COMMITTED;

    // Discard looks at pre-cycle state, so the slot allocated this cycle (FREE before) is immune.
    for (int unsigned i = 0; i < SB_SIZE; i++) begin
      if (discard_i[i] && entries_q[i].state == PENDING && entries_d[i].state == PENDING) begin
        entries_d[i].state = FREE;
        n_disc   = n_disc + 1'b1;
        any_disc = 1'b1;
      end
    end

    if (do_alloc) begin
      entries_d[tail_q].state = PENDING;
      entries_d[tail_q].waddr = alloc_addr_i[31:2];
      entries_d[tail_q].be    = byte_mask(alloc_size_i, alloc_addr_i[1:0]);
      entries_d[tail_q].data  = alloc_data_i << {alloc_addr_i[1:0], 3'b000};
    end

    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_free) - n_disc;
    tail_d  = any_disc ? head_d + count_d[IDX_W-1:0] : tail_q + IDX_W'(do_alloc);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SB_SIZE; i++) entries_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dstate_q   <= D_IDLE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_be_q   <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      dstate_q   <= dstate_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_be_q   <= mem_be_d;
    end
  end

  sb_forward_unit #(
    .SB_SIZE (SB_SIZE),
    .IDX_W   (IDX_W)
  ) u_fwd (
    .entries_i   (entries_q),
    .head_i      (head_q),
    .ld_addr_i   (ld_addr_i),
    .ld_size_i   (ld_size_i),
    .fwd_hit_o   (fwd_hit_o),
    .fwd_data_o  (fwd_data_o),
    .fwd_stall_o (fwd_stall_o)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard of expected memory writes plus forwarding checks.
module tb_store_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        alloc_valid_i = 1'b0;
  logic [31:0] alloc_addr_i = '0;
  logic [31:0] alloc_data_i = '0;
  logic [1:0]  alloc_size_i = '0;
  logic        alloc_ready_o;
  logic [1:0]  alloc_idx_o;
  logic        commit_valid_i = 1'b0;
  logic        commit_store_to_mem_i = 1'b0;
  logic [1:0]  commit_idx_i = '0;
  logic [3:0]  discard_i = '0;
  logic [31:0] ld_addr_i = '0;
  logic [1:0]  ld_size_i = '0;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic        fwd_stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i = 1'b0;
  logic        empty_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  store_buffer #(.SB_SIZE(4)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .alloc_valid_i         (alloc_valid_i),
    .alloc_addr_i          (alloc_addr_i),
    .alloc_data_i          (alloc_data_i),
    .alloc_size_i          (alloc_size_i),
    .alloc_ready_o         (alloc_ready_o),
    .alloc_idx_o           (alloc_idx_o),
    .commit_valid_i        (commit_valid_i),
    .commit_store_to_mem_i (commit_store_to_mem_i),
    .commit_idx_i          (commit_idx_i),
    .discard_i             (discard_i),
    .ld_addr_i             (ld_addr_i),
    .ld_size_i             (ld_size_i),
    .fwd_hit_o             (fwd_hit_o),
    .fwd_data_o            (fwd_data_o),
    .fwd_stall_o           (fwd_stall_o),
    .mem_req_o             (mem_req_o),
    .mem_addr_o            (mem_addr_o),
    .mem_data_o            (mem_data_o),
    .mem_be_o              (mem_be_o),
    .mem_ack_i             (mem_ack_i),
    .empty_o               (empty_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    cyc();
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic alloc(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = addr;
    alloc_data_i  = data;
    alloc_size_i  = size;
    cyc();
    alloc_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [1:0] idx, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be);
    wr_t w;
    commit_valid_i        = 1'b1;
    commit_store_to_mem_i = 1'b1;
    commit_idx_i          = idx;
    w.addr = addr;
    w.data = data;
    w.be   = be;
    exp_q.push_back(w);
    cyc();
    commit_valid_i        = 1'b0;
    commit_store_to_mem_i = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!mem_req_o && n < 20) begin
      cyc();
      n++;
    end
    check(tag, 32'(mem_req_o), 32'd1);
  endtask

  task automatic drain_one(input string tag);
    wr_t w;
    wait_req(tag);
    if (mem_req_o) begin
      mem_ack_i = 1'b1;
      #1;
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
      end else begin
        w = exp_q.pop_front();
        check({tag, "_addr"}, mem_addr_o, w.addr);
        check({tag, "_data"}, mem_data_o, w.data);
        check({tag, "_be"}, 32'(mem_be_o), 32'(w.be));
      end
      cyc();
      mem_ack_i = 1'b0;
    end
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] size);
    ld_addr_i = addr;
    ld_size_i = size;
    #1;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_be", 32'(mem_be_o), 32'd0);
    check("rst_ready", 32'(alloc_ready_o), 32'd1);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_hit", 32'(fwd_hit_o), 32'd0);
    check("rst_stall", 32'(fwd_stall_o), 32'd0);
    cyc();
    rst_i = 1'b0;
    cyc();

    // Single word store: commit at N, request visible at N+2, held until ack
    alloc(32'h100, 32'hDEADBEEF, 2'd2);
    check("t1_empty_after_alloc", 32'(empty_o), 32'd0);
    check("t1_idx", 32'(alloc_idx_o), 32'd1);
    commit(2'd0, 32'h100, 32'hDEADBEEF, 4'hF);
    check("t1_req_n1", 32'(mem_req_o), 32'd0);
    cyc();
    check("t1_req_n2", 32'(mem_req_o), 32'd1);
    cyc();
    check("t1_req_held", 32'(mem_req_o), 32'd1);
    check("t1_addr_held", mem_addr_o, 32'h100);
    drain_one("t1");
    check("t1_req_dropped", 32'(mem_req_o), 32'd0);
    check("t1_empty", 32'(empty_o), 32'd1);

    // Full buffer: fifth alloc ignored, one drain reopens a slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("t2_idx", 32'(alloc_idx_o), 32'(i));
      alloc(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2);
    end
    check("t2_full", 32'(alloc_ready_o), 32'd0);
    alloc(32'h500, 32'h55555555, 2'd2);
    check("t2_full_still", 32'(alloc_ready_o), 32'd0);
    load(32'h500, 2'd2);
    check("t2_ignored_nohit", 32'(fwd_hit_o), 32'd0);
    load(32'h400, 2'd2);
    check("t2_slot0_intact", fwd_data_o, 32'hA0);
    commit(2'd0, 32'h400, 32'hA0, 4'hF);
    check("t2_ready_before_ack", 32'(alloc_ready_o), 32'd0);
    drain_one("t2");
    check("t2_ready_after_ack", 32'(alloc_ready_o), 32'd1);

    // Byte store forwarding: full cover hits, wider load stalls
    do_reset();
    alloc(32'h203, 32'hAA, 2'd0);
    load(32'h203, 2'd0);
    check("t3_byte_hit", 32'(fwd_hit_o), 32'd1);
    check("t3_byte_data", fwd_data_o, 32'hAA000000);
    check("t3_byte_nostall", 32'(fwd_stall_o), 32'd0);
    load(32'h200, 2'd2);
    check("t3_word_stall", 32'(fwd_stall_o), 32'd1);
    check("t3_word_nohit", 32'(fwd_hit_o), 32'd0);
    check("t3_word_data0", fwd_data_o, 32'd0);
    load(32'h202, 2'd0);
    check("t3_disjoint_stall", 32'(fwd_stall_o), 32'd0);
    check("t3_disjoint_hit", 32'(fwd_hit_o), 32'd0);

    // Youngest of two matching stores wins
    alloc(32'h300, 32'h11111111, 2'd2);
    alloc(32'h300, 32'h22222222, 2'd2);
    load(32'h300, 2'd2);
    check("t4_young_hit", 32'(fwd_hit_o), 32'd1);
    check("t4_young_data", fwd_data_o, 32'h22222222);
    load(32'h302, 2'd1);
    check("t4_half_data", fwd_data_o, 32'h22222222);

    // Discard of younger pending stores rewinds tail; committed oldest still drains
    do_reset();
    alloc(32'h600, 32'h60, 2'd2);
    alloc(32'h604, 32'h64, 2'd2);
    alloc(32'h608, 32'h68, 2'd2);
    commit(2'd0, 32'h600, 32'h60, 4'hF);
    discard_i = 4'b0110;
    cyc();
    discard_i = 4'b0000;
    check("t5_tail", 32'(alloc_idx_o), 32'd1);
    load(32'h604, 2'd2);
    check("t5_discarded_nohit", 32'(fwd_hit_o), 32'd0);
    load(32'h600, 2'd2);
    check("t5_draining_fwd", 32'(fwd_hit_o), 32'd1);
    drain_one("t5");
    check("t5_empty", 32'(empty_o), 32'd1);
    alloc(32'h60C, 32'h6C, 2'd2);
    check("t5_next_idx", 32'(alloc_idx_o), 32'd2);

    // Wraparound drain order, then reset mid-handshake
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h800 + 32'(4 * i), 32'h80 + 32'(i), 2'd2);
    for (int i = 0; i < 3; i++) commit(2'(i), 32'h800 + 32'(4 * i), 32'h80 + 32'(i), 4'hF);
    for (int i = 0; i < 3; i++) drain_one("t6_pre");
    check("t6_head3", 32'(alloc_idx_o), 32'd3);
    alloc(32'h700, 32'h70, 2'd2);
    check("t6_wrap_idx", 32'(alloc_idx_o), 32'd0);
    alloc(32'h704, 32'h74, 2'd0);
    commit(2'd3, 32'h700, 32'h70, 4'hF);
    commit(2'd0, 32'h704, 32'h74, 4'h1);
    drain_one("t6_idx3");
    wait_req("t6_idx0_req");
    check("t6_idx0_addr", mem_addr_o, 32'h704);
    rst_i = 1'b1;
    #1;
    check("t6_rst_req", 32'(mem_req_o), 32'd0);
    check("t6_rst_empty", 32'(empty_o), 32'd1);
    check("t6_rst_be", 32'(mem_be_o), 32'd0);
    cyc();
    rst_i = 1'b0;
    exp_q.delete();
    repeat (3) cyc();
    check("t6_no_req_after_rst", 32'(mem_req_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
